// File: rtl/vec_pkg.sv
// Shared types and constants for the vector load unit: FSM state encoding,
// vector geometry, and a helper that drops one memory word into a vector.
package vec_pkg;

   localparam int VLEN      = 128;
   localparam int WORD_W    = 32;
   localparam int BEATS     = 4;
   localparam int REG_IDX_W = 5;
   localparam int BEAT_W    = 2;

   localparam logic [BEAT_W-1:0] LAST_BEAT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WRITE = 2'd3
   } vlu_state_e;

   // Returns vec with word lane idx replaced by w; other lanes untouched.
   function automatic logic [VLEN-1:0] put_word(input logic [VLEN-1:0]   vec,
                                                input logic [BEAT_W-1:0] idx,
                                                input logic [WORD_W-1:0] w);
      logic [VLEN-1:0] r;
      r = vec;
      r[idx*WORD_W +: WORD_W] = w;
      return r;
   endfunction

endpackage

// File: rtl/vector_load_unit.sv
// Loads one 128-bit vector as four sequential 32-bit memory reads and writes
// the assembled value into the vector register file in a single cycle.
module vector_load_unit
   import vec_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [REG_IDX_W-1:0] vd,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [WORD_W-1:0]    mem_rdata,
   input  logic                 mem_rvalid,
   output logic                 wre,
   output logic [REG_IDX_W-1:0] a3,
   output logic [VLEN-1:0]      wd3
);

   localparam logic [ADDR_W-1:0] WORD_STRIDE = ADDR_W'(WORD_W / 8);
   localparam logic [ADDR_W-1:0] ALIGN_MASK  = {{(ADDR_W-2){1'b1}}, 2'b00};

   vlu_state_e            state_r;
   vlu_state_e            state_s;
   logic [BEAT_W-1:0]     beat_r;
   logic [ADDR_W-1:0]     addr_r;
   logic [REG_IDX_W-1:0]  vd_r;
   logic [VLEN-1:0]       buf_r;
   logic                  busy_r;
   logic                  rd_en_r;
   logic                  wre_r;

   // Next-state decode; rvalid only matters while a read is outstanding.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               if (beat_r == LAST_BEAT) begin
                  state_s = ST_WRITE;
               end else begin
                  state_s = ST_REQ;
               end
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_WRITE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and output flops; outputs are decoded from the next state
   // so every port comes straight from a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         beat_r  <= 2'd0;
         addr_r  <= {ADDR_W{1'b0}};
         vd_r    <= {REG_IDX_W{1'b0}};
         buf_r   <= {VLEN{1'b0}};
         busy_r  <= 1'b0;
         rd_en_r <= 1'b0;
         wre_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != ST_IDLE);
         rd_en_r <= (state_s == ST_REQ);
         wre_r   <= (state_s == ST_WRITE);
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  addr_r <= base_addr & ALIGN_MASK;
                  vd_r   <= vd;
                  beat_r <= 2'd0;
                  buf_r  <= {VLEN{1'b0}};
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  buf_r <= put_word(buf_r, beat_r, mem_rdata);
                  // addr_r always holds the address of the next beat to fetch
                  if (beat_r != LAST_BEAT) begin
                     beat_r <= beat_r + 2'd1;
                     addr_r <= addr_r + WORD_STRIDE;
                  end
               end
            end
            default: begin
               beat_r <= beat_r;
            end
         endcase
      end
   end

   assign busy      = busy_r;
   assign mem_rd_en = rd_en_r;
   assign mem_addr  = addr_r;
   assign wre       = wre_r;
   assign done      = wre_r;
   assign a3        = vd_r;
   assign wd3       = buf_r;

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed bench for vector_load_unit: memory responder, cycle model of the
// load protocol with a per-cycle compare, and literal checks per scenario.
module tb_vector_load_unit;

   logic         clk;
   logic         rst;
   logic         start;
   logic [31:0]  base_addr;
   logic [4:0]   vd;
   logic         busy;
   logic         done;
   logic         mem_rd_en;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_rdata;
   logic         mem_rvalid;
   logic         wre;
   logic [4:0]   a3;
   logic [127:0] wd3;

   int checks = 0;
   int errors = 0;

   vector_load_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .vd(vd),
      .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .wre(wre), .a3(a3),
      .wd3(wd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // memory contents: explicit table, otherwise an address-derived pattern
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mv(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [127:0] exp_vec(input logic [31:0] b);
      logic [31:0] a;
      a = b & 32'hFFFF_FFFC;
      return {mv(a + 32'd12), mv(a + 32'd8), mv(a + 32'd4), mv(a)};
   endfunction

   // memory responder: one outstanding read, latency 1 or 1..6 cycles
   int resp_rand = 0;
   int spur_req  = 0;
   initial begin
      int wait_cnt;
      int spur_seen;
      logic [31:0] req_addr;
      wait_cnt = 0; spur_seen = 0; req_addr = 32'd0;
      mem_rvalid = 1'b0; mem_rdata = 32'd0;
      forever begin
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         mem_rdata  = 32'h0BAD_0BAD;
         if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mv(req_addr);
            end
         end else if (spur_req != spur_seen) begin
            spur_seen  = spur_req;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
         end
         if (mem_rd_en) begin
            req_addr = mem_addr;
            wait_cnt = (resp_rand != 0) ? 1 + int'($urandom_range(5, 0)) : 1;
         end
      end
   end

   // protocol model: predicts next-cycle outputs from the inputs at each edge
   logic         m_on = 1'b0;
   logic         e_busy, e_wre, e_rd;
   logic [31:0]  e_addr;
   logic [4:0]   e_a3;
   logic [127:0] e_wd3;
   initial begin
      logic        m_active, m_write, cur_rd;
      logic [31:0] m_base;
      int          m_got;
      m_active = 1'b0; m_write = 1'b0; m_got = 0; m_base = 32'd0;
      e_busy = 1'b0; e_wre = 1'b0; e_rd = 1'b0; e_addr = 32'd0;
      e_a3 = 5'd0; e_wd3 = 128'd0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_on = 1'b1; m_active = 1'b0; m_write = 1'b0; m_got = 0;
            e_busy = 1'b0; e_wre = 1'b0; e_rd = 1'b0; e_addr = 32'd0;
            e_a3 = 5'd0; e_wd3 = 128'd0;
         end else if (m_on) begin
            cur_rd = e_rd;
            e_rd = 1'b0; e_wre = 1'b0;
            if (!m_active) begin
               if (start) begin
                  m_active = 1'b1; m_got = 0;
                  m_base = base_addr & 32'hFFFF_FFFC;
                  e_a3 = vd; e_wd3 = 128'd0;
                  e_rd = 1'b1; e_addr = m_base;
               end
            end else if (m_write) begin
               m_active = 1'b0; m_write = 1'b0;
            end else if (!cur_rd && mem_rvalid) begin
               e_wd3[32*m_got +: 32] = mem_rdata;
               m_got++;
               if (m_got == 4) begin
                  m_write = 1'b1; e_wre = 1'b1;
               end else begin
                  e_rd = 1'b1;
                  e_addr = m_base + 32'(4 * m_got);
               end
            end
            e_busy = m_active;
         end
      end
   end

   // per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         if (m_on) begin
            check("busy", 128'(busy), 128'(e_busy));
            check("done", 128'(done), 128'(e_wre));
            check("wre", 128'(wre), 128'(e_wre));
            check("mem_rd_en", 128'(mem_rd_en), 128'(e_rd));
            check("a3", 128'(a3), 128'(e_a3));
            check("wd3", wd3, e_wd3);
            if (e_rd) check("mem_addr", 128'(mem_addr), 128'(e_addr));
         end
      end
   end

   logic [31:0] addr_q[$];

   task automatic run_load(input logic [31:0] b, input logic [4:0] v,
                           input int extra_at, input logic [31:0] extra_b,
                           output int cyc, output logic [127:0] wd,
                           output logic [4:0] a3o, output int pulses,
                           output int dones);
      addr_q.delete();
      pulses = 0; dones = 0; cyc = -1; wd = 128'd0; a3o = 5'd0;
      base_addr = b; vd = v; start = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (k == extra_at) begin
            start = 1'b1; base_addr = extra_b; vd = ~v;
         end else begin
            start = 1'b0;
         end
         if (mem_rd_en) begin
            addr_q.push_back(mem_addr);
            pulses++;
         end
         if (done) dones++;
         if (wre) begin
            cyc = k; wd = wd3; a3o = a3;
            break;
         end
      end
      start = 1'b0;
      if (cyc < 0) check("load_timeout", 128'd0, 128'd1);
   endtask

   task automatic check_addrs(input string name, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] a3e);
      logic [31:0] exp_a [4];
      exp_a = '{a0, a1, a2, a3e};
      check({name, "_count"}, 128'(addr_q.size()), 128'd4);
      for (int i = 0; i < 4 && i < addr_q.size(); i++)
         check(name, 128'(addr_q[i]), 128'(exp_a[i]));
   endtask

   initial begin
      int cyc, pulses, dones;
      logic [127:0] wd;
      logic [4:0] a3o;
      rst = 1'b1; start = 1'b0; base_addr = 32'd0; vd = 5'd0;
      mem[32'h100] = 32'h1111_1111; mem[32'h104] = 32'h2222_2222;
      mem[32'h108] = 32'h3333_3333; mem[32'h10C] = 32'h4444_4444;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_mem_addr", 128'(mem_addr), 128'd0);
      check("rst_rd_en", 128'(mem_rd_en), 128'd0);
      check("rst_wd3", wd3, 128'd0);
      check("rst_a3", 128'(a3), 128'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // basic load, 1-cycle memory
      run_load(32'h100, 5'd7, 0, 32'd0, cyc, wd, a3o, pulses, dones);
      check("lat9", 128'(cyc), 128'd9);
      check("a3_7", 128'(a3o), 128'd7);
      check("wd3_basic", wd, 128'h44444444_33333333_22222222_11111111);
      check("done_once", 128'(dones), 128'd1);
      check("rd_pulses", 128'(pulses), 128'd4);
      check_addrs("addr_basic", 32'h100, 32'h104, 32'h108, 32'h10C);
      @(posedge clk); #1;

      // unaligned base is forced to word alignment
      run_load(32'h103, 5'd3, 0, 32'd0, cyc, wd, a3o, pulses, dones);
      check_addrs("addr_unaligned", 32'h100, 32'h104, 32'h108, 32'h10C);
      check("wd3_unaligned", wd, 128'h44444444_33333333_22222222_11111111);
      @(posedge clk); #1;

      // address wrap-around
      run_load(32'hFFFF_FFF8, 5'd31, 0, 32'd0, cyc, wd, a3o, pulses, dones);
      check_addrs("addr_wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4);
      check("wd3_wrap", wd, {32'h0000_0004 ^ 32'hC0DE_0000, 32'hC0DE_0000,
                             32'hFFFF_FFFC ^ 32'hC0DE_0000,
                             32'hFFFF_FFF8 ^ 32'hC0DE_0000});
      check("a3_31", 128'(a3o), 128'd31);
      @(posedge clk); #1;

      // random latency, spurious rvalid while idle
      resp_rand = 1;
      for (int t = 0; t < 3; t++) begin
         spur_req++;
         repeat (2) @(posedge clk);
         #1;
         run_load(32'h800 + 32'(t * 64), 5'(12 + t), 0, 32'd0,
                  cyc, wd, a3o, pulses, dones);
         check("wd3_rand", wd, exp_vec(32'h800 + 32'(t * 64)));
         check("rd_pulses_rand", 128'(pulses), 128'd4);
         check("done_rand", 128'(dones), 128'd1);
         repeat (8) @(posedge clk);
         #1;
      end
      resp_rand = 0;

      // reset after the third beat returns aborts the load
      mem[32'h200] = 32'hAAAA_0000; mem[32'h204] = 32'hAAAA_0001;
      mem[32'h208] = 32'hAAAA_0002; mem[32'h20C] = 32'hAAAA_0003;
      base_addr = 32'h200; vd = 5'd9; start = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      check("abort_point_rd", 128'(mem_rd_en), 128'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_wre", 128'(wre), 128'd0);
      repeat (3) @(posedge clk);
      #1;
      mem[32'h200] = 32'h5555_0000; mem[32'h204] = 32'h5555_0001;
      mem[32'h208] = 32'h5555_0002; mem[32'h20C] = 32'h5555_0003;
      run_load(32'h200, 5'd9, 0, 32'd0, cyc, wd, a3o, pulses, dones);
      check("wd3_after_abort", wd, 128'h55550003_55550002_55550001_55550000);
      check("a3_after_abort", 128'(a3o), 128'd9);
      @(posedge clk); #1;

      // start while busy ignored, then back-to-back start after done
      run_load(32'h400, 5'd5, 3, 32'h500, cyc, wd, a3o, pulses, dones);
      check("lat_ignored", 128'(cyc), 128'd9);
      check_addrs("addr_ignored", 32'h400, 32'h404, 32'h408, 32'h40C);
      check("wd3_ignored", wd, exp_vec(32'h400));
      check("a3_ignored", 128'(a3o), 128'd5);
      @(posedge clk); #1;
      run_load(32'h600, 5'd6, 0, 32'd0, cyc, wd, a3o, pulses, dones);
      check("lat_b2b", 128'(cyc), 128'd9);
      check("wd3_b2b", wd, exp_vec(32'h600));
      check("a3_b2b", 128'(a3o), 128'd6);
      repeat (4) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
